regbank_wr_arb: RTL and testbench
=================================

# regbank_wr_arb

Write controller and two-requester arbiter for a bank of 4-bit load-enabled registers. Each bank register is a per-bit capture flop stage followed by a load-gated output stage. This block serialises write requests from two masters with round-robin priority. For each winner it drives the data for one capture cycle, then pulses the one-hot load enable for the addressed register, then acknowledges the requester. It sits between the bus-side masters and the register bank and is the only block that drives bank data and load lines.

## Interface
- NREG, 4, number of bank registers (1..4); addresses >= NREG are invalid
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req0, req1  in  1  write request; level, held high until the matching gnt
- addr0, addr1  in  2  target register index for req0/req1
- data0, data1  in  4  write data for req0/req1
- gnt0, gnt1  out  1  one-cycle acknowledge: the write has committed (or was rejected)
- err  out  1  one-cycle pulse, coincident with gnt, when the granted addr >= NREG
- reg_in  out  4  data to the bank capture stage
- reg_load  out  NREG  one-hot load enable to the bank output stage
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- All outputs are registered. While reset is low, every output is 0, the FSM is in IDLE, and the last-served pointer is 1, so req0 wins the first tie.
- FSM states:
  - IDLE: if any req is high, pick a winner, latch its addr and data internally, load reg_in with the winner's data, and go to CAPTURE. Otherwise stay in IDLE.
  - CAPTURE: hold reg_in while the bank capture flops sample it; reg_load = 0. Next state is COMMIT.
  - COMMIT: reg_load[addr] = 1 for exactly this cycle if addr < NREG, otherwise reg_load = 0 and err = 1. Pulse the winner's gnt and update the last-served pointer.
    - If the other requester's req is high, latch it and go straight to CAPTURE (back-to-back).
    - Otherwise go to IDLE.
- Arbitration: one requester high wins. Both high: the requester that is not last-served wins.
- The just-granted requester's req is ignored in COMMIT, because it is still the old request. If it is high in the cycle after gnt, that is a new request.
- reg_in changes only on entry to CAPTURE and holds its value otherwise, including in IDLE.
- reg_load is never multi-hot and is never high outside COMMIT. gnt0 and gnt1 are never high together.
- Requester addr and data are sampled only at the winning edge. Changes afterwards have no effect on the in-flight write.

## Timing
- Single request from IDLE (req sampled high at edge E0):
  - CAPTURE in cycle E0..E1.
  - COMMIT in cycle E1..E2, with reg_load and gnt high.
  - Bank output updates at E2.
  - Latency from request to gnt is 2 cycles.
- Back-to-back alternating requests: one commit every 2 cycles.
- Same requester repeatedly: one commit every 3 cycles, because that requester passes through IDLE.
- Reset asserted mid-operation (CAPTURE or COMMIT): outputs clear immediately and asynchronously. No load pulse and no gnt for the aborted write; the requester must still be holding req and is re-served after reset release.
- Reset release: the first edge with reset high may already sample req in IDLE.

## Test plan
- Reset, then req0=1, addr0=2, data0=4'b0011 held: reg_in=0011 for 2 cycles, reg_load=4'b0100 and gnt0 pulse on the second cycle, busy high for 2 cycles.
- req0 and req1 both high from reset (addr 0 / data 0001, addr 3 / data 1000):
  - gnt order is 0, 1, 0, 1, with commits every 2 cycles.
  - reg_load alternates 0001 / 1000.
  - gnt0 and gnt1 are never simultaneous.
- NREG=3, req1 with addr1=3: gnt1 and err pulse together, reg_load stays 000, FSM returns to IDLE.
- Change data0 from 0010 to 0100 in the CAPTURE cycle: reg_in stays 0010 and the committed value is 0010.
- Drop reset low during CAPTURE: all outputs 0 within the same cycle, no reg_load pulse. After release with req0 still high, the write completes 2 cycles later.
- Sweep addr0 = 0..3 with random data: check bank contents after each gnt and confirm reg_load is one-hot per commit.

Source files
------------

// File: rtl/regbank_wr_arb_if.sv
// Requester and bank-side signals of the register bank write arbiter.
// The slave modport is the arbiter's view; master is the requester/bank environment.
interface regbank_wr_arb_if #(
    parameter int unsigned NREG = 4
);
    logic            req0;
    logic            req1;
    logic [1:0]      addr0;
    logic [1:0]      addr1;
    logic [3:0]      data0;
    logic [3:0]      data1;
    logic            gnt0;
    logic            gnt1;
    logic            err;
    logic [3:0]      reg_in;
    logic [NREG-1:0] reg_load;
    logic            busy;

    modport master (
        output req0, req1, addr0, addr1, data0, data1,
        input  gnt0, gnt1, err, reg_in, reg_load, busy
    );

    modport slave (
        input  req0, req1, addr0, addr1, data0, data1,
        output gnt0, gnt1, err, reg_in, reg_load, busy
    );
endinterface

// File: rtl/regbank_wr_arb.sv
// Round-robin write arbiter for two requesters driving a bank of 4-bit registers:
// data is presented for one capture cycle, then a one-hot load pulse commits it.
module regbank_wr_arb #(
    parameter int unsigned NREG = 4
) (
    input  logic             clk,
    input  logic             reset,
    regbank_wr_arb_if.slave  bus
);
    localparam int unsigned AW = 2;
    localparam int unsigned DW = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            cur_q, cur_d;
    logic            last_q, last_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   reg_in_q, reg_in_d;
    logic [NREG-1:0] load_q, load_d;
    logic            gnt0_q, gnt0_d;
    logic            gnt1_q, gnt1_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;

    logic            pick_c;
    logic            other_req_c;
    logic            sel_c;
    logic [AW-1:0]   sel_addr_c;
    logic [DW-1:0]   sel_data_c;
    logic            addr_ok_c;
    logic [NREG-1:0] addr_dec_c;

    // Arbitration: a lone request wins; on a tie the requester not served last wins.
    always_comb begin
        pick_c      = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
        other_req_c = cur_q ? bus.req0 : bus.req1;
        sel_c       = (state_q == COMMIT) ? ~cur_q : pick_c;
        sel_addr_c  = sel_c ? bus.addr1 : bus.addr0;
        sel_data_c  = sel_c ? bus.data1 : bus.data0;
    end

    // Address check and one-hot decode of the latched target register.
    always_comb begin
        addr_ok_c  = {1'b0, addr_q} < 3'(NREG);
        addr_dec_c = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            addr_dec_c[i] = (addr_q == AW'(i));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cur_q    <= 1'b0;
            last_q   <= 1'b1;
            addr_q   <= '0;
            reg_in_q <= '0;
            load_q   <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            reg_in_q <= reg_in_d;
            load_q   <= load_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    // Next state; pulse outputs are computed one edge early so they are registered in COMMIT.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        last_d   = last_q;
        addr_d   = addr_q;
        reg_in_d = reg_in_q;
        load_d   = '0;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    cur_d    = sel_c;
                    addr_d   = sel_addr_c;
                    reg_in_d = sel_data_c;
                    state_d  = CAPTURE;
                end
            end
            CAPTURE: begin
                load_d  = addr_ok_c ? addr_dec_c : '0;
                err_d   = ~addr_ok_c;
                gnt0_d  = ~cur_q;
                gnt1_d  = cur_q;
                state_d = COMMIT;
            end
            COMMIT: begin
                // The winner's own req is still the old request here, so only the other side is looked at.
                last_d = cur_q;
                if (other_req_c) begin
                    cur_d    = sel_c;
                    addr_d   = sel_addr_c;
                    reg_in_d = sel_data_c;
                    state_d  = CAPTURE;
                end else begin
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.err      = err_q;
    assign bus.reg_in   = reg_in_q;
    assign bus.reg_load = load_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_regbank_wr_arb.sv
// Directed bench for regbank_wr_arb: scoreboard of expected commits plus a behavioural
// model of the register bank driven by reg_in/reg_load.
module tb_regbank_wr_arb;
    logic clk;
    logic reset;

    regbank_wr_arb_if #(.NREG(4)) b4 ();
    regbank_wr_arb_if #(.NREG(3)) b3 ();

    regbank_wr_arb #(.NREG(4)) dut4 (.clk(clk), .reset(reset), .bus(b4.slave));
    regbank_wr_arb #(.NREG(3)) dut3 (.clk(clk), .reset(reset), .bus(b3.slave));

    typedef struct {
        bit       who;
        bit [1:0] addr;
        bit [3:0] data;
        bit       err;
    } exp_t;

    exp_t     sb[$];
    int       ntotal = 0;
    int       npass  = 0;
    bit       pend   = 0;
    bit [1:0] pend_addr;
    bit [3:0] pend_data;

    logic [3:0] cap;
    logic [3:0] bank [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank model: capture flops sample reg_in every edge, output stage loads on reg_load.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap <= '0;
            for (int i = 0; i < 4; i++) bank[i] <= '0;
        end else begin
            cap <= b4.reg_in;
            for (int i = 0; i < 4; i++) if (b4.reg_load[i]) bank[i] <= cap;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input bit who, input bit [1:0] addr, input bit [3:0] data);
        exp_t e;
        e.who  = who;
        e.addr = addr;
        e.data = data;
        e.err  = 1'b0;
        sb.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        chk("gnt_exclusive", 32'(b4.gnt0 & b4.gnt1), 32'd0);
        chk("load_onehot0", 32'($countones(b4.reg_load) <= 1), 32'd1);
        chk("load_outside_commit", 32'(b4.reg_load & {4{~(b4.gnt0 | b4.gnt1)}}), 32'd0);
        if (pend) begin
            chk("bank_content", 32'(bank[pend_addr]), 32'(pend_data));
            pend = 1'b0;
        end
        if (b4.gnt0 || b4.gnt1) begin
            if (sb.size() == 0) begin
                chk("unexpected_gnt", 32'({b4.gnt1, b4.gnt0}), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("gnt_who", 32'(b4.gnt1), 32'(e.who));
                chk("commit_err", 32'(b4.err), 32'(e.err));
                chk("commit_reg_in", 32'(b4.reg_in), 32'(e.data));
                chk("commit_reg_load", 32'(b4.reg_load), e.err ? 32'd0 : 32'(4'b0001 << e.addr));
                if (!e.err) begin
                    pend      = 1'b1;
                    pend_addr = e.addr;
                    pend_data = e.data;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("gnt_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        int n;
        int ng;
        int prev;
        int first;
        bit [3:0] d;

        reset = 1'b0;
        b4.req0 = 0; b4.req1 = 0; b4.addr0 = 0; b4.addr1 = 0; b4.data0 = 0; b4.data1 = 0;
        b3.req0 = 0; b3.req1 = 0; b3.addr0 = 0; b3.addr1 = 0; b3.data0 = 0; b3.data1 = 0;

        // Reset state
        #2;
        chk("rst_busy", 32'(b4.busy), 32'd0);
        chk("rst_gnt", 32'({b4.gnt1, b4.gnt0, b4.err}), 32'd0);
        chk("rst_reg_in", 32'(b4.reg_in), 32'd0);
        chk("rst_reg_load", 32'(b4.reg_load), 32'd0);
        chk("rst3_outputs", 32'({b3.busy, b3.gnt1, b3.gnt0, b3.err, b3.reg_load, b3.reg_in}), 32'd0);
        tick();
        reset = 1'b1;

        // Single write: req0 addr 2 data 0011
        b4.req0 = 1; b4.addr0 = 2'd2; b4.data0 = 4'b0011;
        push(0, 2'd2, 4'b0011);
        tick();
        chk("single_capture_busy", 32'(b4.busy), 32'd1);
        chk("single_capture_reg_in", 32'(b4.reg_in), 32'h3);
        chk("single_capture_load", 32'(b4.reg_load), 32'd0);
        chk("single_capture_gnt", 32'(b4.gnt0), 32'd0);
        tick();
        chk("single_latency", 32'(sb.size()), 32'd0);
        chk("single_commit_busy", 32'(b4.busy), 32'd1);
        b4.req0 = 0;
        tick();
        chk("single_idle_busy", 32'(b4.busy), 32'd0);
        chk("single_idle_reg_in", 32'(b4.reg_in), 32'h3);

        // Both requesters from reset: alternating 0,1,0,1 every 2 cycles
        pulse_reset();
        b4.req0 = 1; b4.addr0 = 2'd0; b4.data0 = 4'b0001;
        b4.req1 = 1; b4.addr1 = 2'd3; b4.data1 = 4'b1000;
        push(0, 2'd0, 4'b0001); push(1, 2'd3, 4'b1000);
        push(0, 2'd0, 4'b0001); push(1, 2'd3, 4'b1000);
        ng = 0; prev = 0; first = 0;
        for (int t = 1; t <= 20 && ng < 4; t++) begin
            tick();
            if (b4.gnt0 || b4.gnt1) begin
                ng++;
                if (ng == 1) first = t;
                else chk("b2b_period", 32'(t - prev), 32'd2);
                prev = t;
                if (ng == 4) begin
                    b4.req0 = 0;
                    b4.req1 = 0;
                end
            end
        end
        chk("b2b_count", 32'(ng), 32'd4);
        chk("b2b_first_latency", 32'(first), 32'd2);
        tick();
        chk("b2b_idle", 32'(b4.busy), 32'd0);

        // Invalid address on the 3-register instance
        b3.req1 = 1; b3.addr1 = 2'd3; b3.data1 = 4'b0101;
        tick();
        chk("inv_capture_busy", 32'(b3.busy), 32'd1);
        tick();
        chk("inv_gnt1", 32'(b3.gnt1), 32'd1);
        chk("inv_err", 32'(b3.err), 32'd1);
        chk("inv_gnt0", 32'(b3.gnt0), 32'd0);
        chk("inv_reg_load", 32'(b3.reg_load), 32'd0);
        b3.req1 = 0;
        tick();
        chk("inv_idle", 32'({b3.busy, b3.err, b3.gnt1}), 32'd0);

        // Data change during CAPTURE must not affect the in-flight write
        b4.req0 = 1; b4.addr0 = 2'd1; b4.data0 = 4'b0010;
        push(0, 2'd1, 4'b0010);
        tick();
        b4.data0 = 4'b0100;
        b4.addr0 = 2'd2;
        chk("hold_reg_in", 32'(b4.reg_in), 32'h2);
        tick();
        b4.req0 = 0;
        tick();
        chk("hold_reg_in_idle", 32'(b4.reg_in), 32'h2);

        // Reset during CAPTURE aborts the write; requester is re-served after release
        b4.req0 = 1; b4.addr0 = 2'd3; b4.data0 = 4'b1001;
        tick();
        chk("abort_capture_busy", 32'(b4.busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("abort_async_clear", 32'({b4.busy, b4.gnt1, b4.gnt0, b4.err, b4.reg_load, b4.reg_in}), 32'd0);
        tick();
        chk("abort_no_load", 32'(b4.reg_load), 32'd0);
        reset = 1'b1;
        push(0, 2'd3, 4'b1001);
        wait_gnt(n);
        chk("abort_relatency", 32'(n), 32'd2);
        b4.req0 = 0;
        tick();

        // Address sweep with random data
        for (int a = 0; a < 4; a++) begin
            d = 4'($urandom_range(0, 15));
            b4.req0 = 1; b4.addr0 = 2'(a); b4.data0 = d;
            push(0, 2'(a), d);
            wait_gnt(n);
            chk("sweep_latency", 32'(n), 32'd2);
            b4.req0 = 0;
            tick();
        end
        tick();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
